// File: rtl/mux_pkg.sv
// Shared select encodings for the mux family.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage : mux_pkg

// File: rtl/dec2to4.sv
// 2-to-4 one-hot decoder; purely combinational, shared by the mux variants.
module dec2to4
  import mux_pkg::*;
(
  input  sel_t       sel_i,
  output logic [3:0] en_o
);

  // Exactly one enable bit is high for any known select value.
  always_comb begin
    en_o = 4'b0000;
    unique case (sel_i)
      SEL_A: en_o = 4'b0001;
      SEL_B: en_o = 4'b0010;
      SEL_C: en_o = 4'b0100;
      SEL_D: en_o = 4'b1000;
      default: en_o = 4'b0000;
    endcase
  end

endmodule : dec2to4

// File: rtl/my_mux_v2.sv
// WIDTH-bit 4:1 mux: one-hot decode, AND-OR data path, optional output register.
module my_mux_v2
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y
);

  sel_t       sel;
  logic [3:0] en;

  assign sel = {s1, s0};

  dec2to4 u_dec (
    .sel_i (sel),
    .en_o  (en)
  );

  // AND-OR steering: the one-hot enable gates exactly one input onto the result.
  always_comb begin
    y_comb = (a & {WIDTH{en[0]}}) | (b & {WIDTH{en[1]}}) |
             (c & {WIDTH{en[2]}}) | (d & {WIDTH{en[3]}});
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    // Every edge reloads the register; no hold or enable.
    always_comb begin
      y_d = y_comb;
    end

    // Output register, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        y_q <= '0;
      end else begin
        y_q <= y_d;
      end
    end

    assign y = y_q;
  end else begin : g_comb
    // Zero-latency variant: reset deliberately has no effect here.
    assign y = y_comb;
  end

endmodule : my_mux_v2

// File: tb/tb_my_mux_v2.sv
// Directed self-checking bench for my_mux_v2 across several parameterisations.
module tb_my_mux_v2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s0  = 1'b0;
  logic s1  = 1'b0;

  logic        a1 = '0, b1 = '0, c1 = '0, d1 = '0;
  logic        yc1, y1;
  logic [7:0]  a8 = '0, b8 = '0, c8 = '0, d8 = '0;
  logic [7:0]  yc8, y8, yc8c, y8c;
  logic [15:0] a16 = '0, b16 = '0, c16 = '0, d16 = '0;
  logic [15:0] yc16, y16;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  my_mux_v2 #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1),
    .a(a1), .b(b1), .c(c1), .d(d1), .y_comb(yc1), .y(y1)
  );

  my_mux_v2 #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1),
    .a(a8), .b(b8), .c(c8), .d(d8), .y_comb(yc8), .y(y8)
  );

  my_mux_v2 #(.WIDTH(8), .REG_OUT(1'b0)) dut8c (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1),
    .a(a8), .b(b8), .c(c8), .d(d8), .y_comb(yc8c), .y(y8c)
  );

  my_mux_v2 #(.WIDTH(16), .REG_OUT(1'b1)) dut16 (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1),
    .a(a16), .b(b16), .c(c16), .d(d16), .y_comb(yc16), .y(y16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // WIDTH=1 sweep vectors: {s1,s0,a,b,c,d,expected_y}
  localparam int NVEC = 7;
  logic [6:0] vec [NVEC] = '{
    7'b00_1000_1, 7'b11_1010_0, 7'b01_0110_1, 7'b10_0100_0,
    7'b00_0110_0, 7'b01_0010_0, 7'b11_0111_1
  };

  logic [15:0] exp16;
  logic [6:0]  v;

  initial begin
    // Reset behaviour
    rst = 1'b1; {s1, s0} = 2'b00; a1 = 1'b1;
    #1;
    check_eq("rst_y_async", 64'(y1), 64'h0);
    check_eq("rst_ycomb", 64'(yc1), 64'h1);
    tick();
    check_eq("rst_y_held1", 64'(y1), 64'h0);
    tick();
    check_eq("rst_y_held2", 64'(y1), 64'h0);
    check_eq("rst_y16", 64'(y16), 64'h0);
    rst = 1'b0;
    #1;
    check_eq("rst_release_no_edge", 64'(y1), 64'h0);
    tick();
    check_eq("rst_first_capture", 64'(y1), 64'h1);

    // Full select sweep, WIDTH=1
    for (int i = 0; i < NVEC; i++) begin
      v = vec[i];
      {s1, s0, a1, b1, c1, d1} = v[6:1];
      #1;
      check_eq($sformatf("sweep_comb%0d", i), 64'(yc1), 64'(v[0]));
      tick();
      check_eq($sformatf("sweep_y%0d", i), 64'(y1), 64'(v[0]));
    end

    // Isolation, WIDTH=8
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h44; d8 = 8'h88;
    for (int i = 0; i < 4; i++) begin
      {s1, s0} = 2'(i);
      #1;
      check_eq($sformatf("iso_comb%0d", i), 64'(yc8), 64'(8'h11 << i));
      tick();
      check_eq($sformatf("iso_y%0d", i), 64'(y8), 64'(8'h11 << i));
    end

    // Async reset mid-stream
    {s1, s0} = 2'b11; d8 = 8'hFF;
    tick();
    check_eq("mid_before", 64'(y8), 64'hFF);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_async_clear", 64'(y8), 64'h00);
    check_eq("mid_ycomb_unaffected", 64'(yc8), 64'hFF);
    check_eq("regout0_ignores_rst", 64'(y8c), 64'hFF);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_still_clear", 64'(y8), 64'h00);
    tick();
    check_eq("mid_recover", 64'(y8), 64'hFF);

    // REG_OUT=0 zero latency
    c8 = 8'hA5; b8 = 8'h5A; {s1, s0} = 2'b10;
    #1;
    check_eq("regout0_c", 64'(y8c), 64'hA5);
    {s1, s0} = 2'b01;
    #1;
    check_eq("regout0_b", 64'(y8c), 64'h5A);
    tick();

    // Randomized run, WIDTH=16, against a reference selection
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom);
      c16 = 16'($urandom); d16 = 16'($urandom);
      {s1, s0} = 2'($urandom_range(0, 3));
      case ({s1, s0})
        2'b00:   exp16 = a16;
        2'b01:   exp16 = b16;
        2'b10:   exp16 = c16;
        default: exp16 = d16;
      endcase
      #1;
      check_eq("rand_comb", 64'(yc16), 64'(exp16));
      tick();
      check_eq("rand_y", 64'(y16), 64'(exp16));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_my_mux_v2
